// File: rtl/cnn_mac_pkg.sv
// Shared constants and helpers for the CNN multiply-accumulate lane.
package cnn_mac_pkg;

  localparam int DEF_A_W   = 14;
  localparam int DEF_B_W   = 9;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 8;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'd0,
    CLIP_HI   = 2'd1,
    CLIP_LO   = 2'd2
  } clip_e;

  // Half-LSB offset so the arithmetic shift rounds half up.
  function automatic logic signed [MAX_W-1:0] round_ofs(input int shift);
    logic signed [MAX_W-1:0] one;
    one = MAX_W'(1);
    return (shift > 0) ? (one <<< (shift - 1)) : '0;
  endfunction

  // Classifies a rescaled sum against the signed out_w-bit range.
  function automatic clip_e sat_clip(input logic signed [MAX_W-1:0] v, input int out_w);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = MAX_W'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = ~hi;
    if (v > hi)      return CLIP_HI;
    else if (v < lo) return CLIP_LO;
    else             return CLIP_NONE;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_reg.sv
// Registered signed multiplier: operand stage then product stage, both held by en.
module cnn_mac_mul_reg #(
  parameter int A_W = 14,
  parameter int B_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               first,
  input  logic               last,
  input  logic               valid,
  output logic [A_W+B_W-1:0] prod,
  output logic               prod_first,
  output logic               prod_last,
  output logic               prod_valid
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  first_q;
  logic                  last_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      prod       <= '0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
      prod_valid <= 1'b0;
    end else if (en) begin
      a_q        <= a;
      b_q        <= b;
      first_q    <= first;
      last_q     <= last;
      valid_q    <= valid;
      prod       <= P_W'(a_q) * P_W'(b_q);
      prod_first <= first_q;
      prod_last  <= last_q;
      prod_valid <= valid_q;
    end
  end

endmodule

// File: rtl/cnn_mac_pipe.sv
// One dot-product lane: multiply, accumulate per vector, round/saturate on the last beat.
// Four cycles from last-beat acceptance to out_valid; the whole pipe freezes while a result waits.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int P_W = A_W + B_W;
  localparam logic signed [ACC_W:0] RND_OFS = (ACC_W+1)'(round_ofs(SHIFT));
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    stall;
  logic                    en;
  logic [P_W-1:0]          prod;
  logic                    prod_first;
  logic                    prod_last;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic                    res_vld;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   scaled;
  clip_e                   clip;
  logic [OUT_W-1:0]        dout_nxt;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  cnn_mac_mul_reg #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (en),
    .a         (din0),
    .b         (din1),
    .first     (in_first),
    .last      (in_last),
    .valid     (in_valid),
    .prod      (prod),
    .prod_first(prod_first),
    .prod_last (prod_last),
    .prod_valid(prod_valid)
  );

  assign prod_ext = ACC_W'($signed(prod));

  // Accumulator wraps modulo 2^ACC_W; sizing ACC_W is the integrator's job.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc     <= '0;
      res_vld <= 1'b0;
    end else if (en) begin
      if (prod_valid) acc <= prod_first ? prod_ext : acc + prod_ext;
      res_vld <= prod_valid & prod_last;
    end
  end

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  always_comb begin
    rnd      = (ACC_W+1)'(acc) + RND_OFS;
    scaled   = rnd >>> SHIFT;
    clip     = sat_clip(MAX_W'(scaled), OUT_W);
    dout_nxt = scaled[OUT_W-1:0];
    if (clip == CLIP_HI)      dout_nxt = SAT_MAX;
    else if (clip == CLIP_LO) dout_nxt = SAT_MIN;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dout      <= '0;
      dout_sat  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= res_vld;
      if (res_vld) begin
        dout     <= dout_nxt;
        dout_sat <= (clip != CLIP_NONE);
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Drives one beat stream into SHIFT=0 and SHIFT=8 lanes and scores both against a dot-product model.
module tb_cnn_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] din0 = '0;
  logic [8:0]  din1 = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready0, in_ready8, ov0, ov8, sat0, sat8;
  logic [15:0] dout0, dout8;

  int  checks = 0;
  int  errors = 0;
  bit  rand_bp = 1'b0;
  bit  prev_stall = 1'b0;
  logic [15:0] prev_dout0, prev_dout8;

  typedef struct {
    longint v0;
    bit     s0;
    longint v8;
    bit     s8;
  } exp_t;
  exp_t   exp_q[$];
  longint sum = 0;

  always #5 clk = ~clk;

  cnn_mac_pipe #(.A_W(14), .B_W(9), .ACC_W(32), .OUT_W(16), .SHIFT(0)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready0),
    .dout(dout0), .dout_sat(sat0), .out_valid(ov0), .out_ready(out_ready)
  );

  cnn_mac_pipe #(.A_W(14), .B_W(9), .ACC_W(32), .OUT_W(16), .SHIFT(8)) u_dut8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready8),
    .dout(dout8), .dout_sat(sat8), .out_valid(ov8), .out_ready(out_ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Rescale with round-half-up, then clip to the signed 16-bit range.
  function automatic void ref_out(input longint s, input int sh, output longint v, output bit sat);
    longint r;
    r = s;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    sat = 1'b1;
    if (r > 32767)       v = 32767;
    else if (r < -32768) v = -32768;
    else begin v = r; sat = 1'b0; end
  endfunction

  task automatic model_accept(input int a, input int b, input bit f, input bit l);
    exp_t e;
    longint p;
    p   = longint'(a) * longint'(b);
    sum = f ? p : sum + p;
    sum = longint'(int'(sum));
    if (l) begin
      ref_out(sum, 0, e.v0, e.s0);
      ref_out(sum, 8, e.v8, e.s8);
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that takes the beat.
  task automatic send(input int a, input int b, input bit f, input bit l);
    din0 = 14'(a);
    din1 = 9'(b);
    in_first = f;
    in_last = l;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready0) begin
        model_accept(a, b, f, l);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ov0) return;
    end
    check("ov_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-hold monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ov0 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ov8", ov8, 1);
          check("dout_s0", longint'($signed(dout0)), e.v0);
          check("sat_s0", sat0, e.s0);
          check("dout_s8", longint'($signed(dout8)), e.v8);
          check("sat_s8", sat8, e.s8);
        end
      end
      if (ov0 && !out_ready) begin
        check("in_ready_stall", in_ready0, 0);
        if (prev_stall) begin
          check("hold_s0", dout0, prev_dout0);
          check("hold_s8", dout8, prev_dout8);
        end
      end
      prev_stall = ov0 && !out_ready;
      prev_dout0 = dout0;
      prev_dout8 = dout8;
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ov", ov0, 0);
    check("rst_dout", dout0, 0);
    check("rst_sat", sat0, 0);
    check("rst_in_ready", in_ready0, 1);
    @(posedge clk);
    #1;

    // Basic vector with latency measurement.
    send(100, 50, 1, 0);
    send(-200, 30, 0, 0);
    send(300, -4, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_early", ov0, 0);
    end
    @(negedge clk);
    check("lat_ov", ov0, 1);
    check("basic_s0", longint'($signed(dout0)), -2200);
    check("basic_s8", longint'($signed(dout8)), -9);
    drain();

    // Saturation and its in-range mirror.
    for (int i = 0; i < 4; i++) send(-8192, -256, i == 0, i == 3);
    wait_ov();
    check("sat_hi_dout", longint'($signed(dout8)), 32767);
    check("sat_hi_flag", sat8, 1);
    drain();
    for (int i = 0; i < 4; i++) send(-8192, 255, i == 0, i == 3);
    wait_ov();
    check("mirror_dout", longint'($signed(dout8)), -32640);
    check("mirror_flag", sat8, 0);
    drain();

    // Back-to-back single-beat vectors.
    send(7, -3, 1, 1);
    send(2, 2, 1, 1);
    wait_ov();
    check("b2b_first", longint'($signed(dout0)), -21);
    @(negedge clk);
    check("b2b_ov", ov0, 1);
    check("b2b_second", longint'($signed(dout0)), 4);
    drain();

    // Backpressure: a result waits 5 cycles while the next vector queues up.
    out_ready = 1'b0;
    send(1000, 20, 1, 0);
    send(5, 5, 0, 0);
    send(-7, 100, 0, 1);
    fork
      begin
        send(30, 40, 1, 0);
        send(-50, 60, 0, 0);
        send(70, -80, 0, 1);
      end
      begin
        wait_ov();
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a vector.
    send(500, 3, 1, 0);
    send(-20, 9, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ov", ov0, 0);
    check("mid_rst_dout", dout0, 0);
    check("mid_rst_ready", in_ready0, 1);
    @(posedge clk);
    #1;
    send(10, 10, 1, 1);
    wait_ov();
    check("post_rst_dout", longint'($signed(dout0)), 100);
    drain();

    // Randomized vectors with random gaps and backpressure.
    rand_bp = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 511)) - 256,
             i == 0, i == len - 1);
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the CNN conv/dense datapath.
- Successor to the fixed-width combinational multiplier primitives: generic operand widths, registered DSP-friendly stages, per-vector accumulation, rounding/saturation to the layer output format, and ready/valid flow control.
- One instance computes one dot-product lane. It sits between the line-buffer/weight fetch and the activation/pool stage.

Parameters:
- A_W, 14, signed activation operand width
- B_W, 9, signed weight operand width
- ACC_W, 32, accumulator width; must be >= A_W+B_W+ceil(log2(max vector length))
- OUT_W, 16, signed result width
- SHIFT, 8, arithmetic right shift applied to the accumulator before saturation (fixed-point rescale); 0 allowed

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  synchronous, active-low reset
- din0  in  A_W  signed activation
- din1  in  B_W  signed weight
- in_first  in  1  beat is the first of a vector; the accumulator restarts
- in_last  in  1  beat is the last of a vector; a result is emitted
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- dout  out  OUT_W  rounded, saturated dot product
- dout_sat  out  1  dout was clipped
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout

Behaviour:
- Reset (ap_rst_n=0 at an edge): all pipeline valid bits, the accumulator, dout, dout_sat and out_valid go to 0. in_ready is 1 in the cycle after reset. Reset mid-vector discards the partial sum and any in-flight beats.
- Stall signal: stall = out_valid & ~out_ready. in_ready = ~stall. All stages hold while stall=1. A beat is accepted when in_valid & in_ready.
- S1: register din0, din1, first, last and valid.
- S2: product p = signed(a)*signed(b), full width A_W+B_W, registered.
- S3: if first, acc <= sext(p); otherwise acc <= acc + sext(p).
  - Addition wraps modulo 2^ACC_W; no overflow detection at this stage.
  - When first and last are on the same beat, the result is sext(p).
- Output: when a last beat leaves S3, r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in ACC_W+1 bits (round half up).
  - If r > 2^(OUT_W-1)-1: dout = max and dout_sat=1.
  - If r < -2^(OUT_W-1): dout = min and dout_sat=1.
  - Otherwise dout = r and dout_sat=0.
  - out_valid is set the following cycle.
- Latency: 4 cycles from acceptance of the last beat to out_valid with no stall. Throughput is 1 beat/cycle.
- out_valid clears on out_valid & out_ready unless a new result is produced in the same cycle, in which case it stays 1 with the new data.
- dout and dout_sat hold stable while stall=1.
- A non-first beat arriving with no open vector (no first since reset or since the last result) accumulates onto the current acc. This is the upstream's responsibility and is not checked.
- Beats without in_last produce no output.

Decomposition:
- Shared package cnn_mac_pkg holds:
  - the saturation helper function (ACC_W to OUT_W, with sat flag)
  - the rounding-offset constant function
  - the default width constants (A_W/B_W/OUT_W/SHIFT) used by the layer wrappers.
- One sub-module, cnn_mac_mul_reg: the registered signed multiplier (S1+S2) with a hold enable, so synthesis maps it to DSP48 A/B/M registers.

Test Plan:
- Basic vector, SHIFT=0, out_ready=1:
  - Stimulus: beats (100,50,first), (-200,30), (300,-4,last).
  - Required: dout=-2200, dout_sat=0, out_valid exactly 4 cycles after the last beat is accepted.
- Rounding, SHIFT=8, same vector:
  - Required: dout=-9, since (-2200+128)>>>8 = -9.
- Saturation, SHIFT=8:
  - Stimulus: four beats (-8192,-256) giving sum 8388608.
  - Required: dout=32767, dout_sat=1.
  - Mirror case with (-8192,255) ×4 (sum -8355840, rescaled -32640, in range): required dout=-32640, dout_sat=0.
- Single-beat vector and back-to-back:
  - Stimulus: (7,-3,first+last) followed next cycle by (2,2,first+last), SHIFT=0.
  - Required: dout=-21, then dout=4 on consecutive cycles; acc does not carry over.
- Backpressure:
  - Stimulus: out_ready held 0 for 5 cycles while a result is valid.
  - Required: in_ready=0 during the stall, dout stable, no beats lost. The next vector's result is correct after out_ready returns to 1.
- Reset mid-vector:
  - Stimulus: ap_rst_n=0 for 1 cycle after 2 of 3 beats, then a fresh vector (10,10,first+last).
  - Required: out_valid=0 and dout=0 after reset, then dout=100 with no residue from the aborted vector.
